b01_collector: RTL and testbench

Downstream deserializer for the b01 serial comparator FSM. It samples b01's registered `outp`/`overflw` pair on qualified cycles and packs `outp` LSB-first into WIDTH-bit words. Each word carries a per-word overflow flag. Completed words go to a consumer over a single-entry valid/ready output register. The block also keeps a saturating count of overflow-tagged words and a sticky drop flag.

---
 rtl/b01_collector.sv | 180 ++++++++++++++++++
 tb/tb_b01_collector.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/b01_collector.sv
// b01_collector: deserializer behind the b01 serial comparator.
//
// This block samples the outp/overflw pair on cycles where sample=1.
// It packs outp LSB-first into WIDTH-bit words. Each word carries an
// overflow flag. Finished words go out through a single-entry
// valid/ready register.
//
// Optional feature macro: B01_COLLECTOR_PARITY_EN
//   When defined, the block adds an out_par output (XOR of out_word).
//   A word with odd parity is also flagged in out_ovf.
//
// Output register FSM:
//   state    | meaning
//   ST_EMPTY | no unconsumed word, out_valid=0
//   ST_FULL  | out_word/out_ovf hold a word not yet accepted, out_valid=1

module b01_collector #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             outp,
    input  logic             overflw,
    input  logic             sample,
    output logic [WIDTH-1:0] out_word,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] ovf_count,
    output logic             dropped
`ifdef B01_COLLECTOR_PARITY_EN
    ,
    output logic             out_par
`endif
);

    localparam int BCNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [WIDTH-1:0]  r_sreg;
    logic [BCNT_W-1:0] r_bcnt;
    logic              r_acc_ovf;

    logic [WIDTH-1:0]  r_out_word;
    logic              r_out_ovf;
    logic [CNT_W-1:0]  r_ovf_count;
    logic              r_dropped;

    logic              w_complete;
    logic [WIDTH-1:0]  w_cand_word;
    logic              w_cand_ovf;
    logic              w_fire;
    logic              w_load;
    logic              w_drop;

    // The final bit completes the word in the same cycle it arrives, so the
    // candidate word is built from the incoming bit plus the shift register.
    assign w_complete  = sample && (r_bcnt == BCNT_LAST);
    assign w_cand_word = {outp, r_sreg[WIDTH-1:1]};
`ifdef B01_COLLECTOR_PARITY_EN
    assign w_cand_ovf  = r_acc_ovf | overflw | (^w_cand_word);
`else
    assign w_cand_ovf  = r_acc_ovf | overflw;
`endif
    assign w_fire      = (r_state == ST_FULL) && out_ready;

    // Shift in qualified bits and track the bit position and overflow
    // accumulator of the word currently being assembled.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sreg    <= '0;
            r_bcnt    <= '0;
            r_acc_ovf <= 1'b0;
        end else if (sample) begin
            r_sreg <= {outp, r_sreg[WIDTH-1:1]};
            if (w_complete) begin
                r_bcnt    <= '0;
                r_acc_ovf <= 1'b0;
            end else begin
                r_bcnt    <= r_bcnt + 1'b1;
                r_acc_ovf <= r_acc_ovf | overflw;
            end
        end
    end

    // Output register state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Decide load/drop and the next output register state. When the word
    // completes while the register is full, it is loaded only if the
    // current word is handed off in that same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_complete) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_complete) begin
                    if (w_fire) begin
                        w_load = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                    w_state_nxt = ST_FULL;
                end else if (w_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Output data, saturating overflow-word count and sticky drop flag.
    // The data fields keep their last value after a handoff.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_word  <= '0;
            r_out_ovf   <= 1'b0;
            r_ovf_count <= '0;
            r_dropped   <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_word <= w_cand_word;
                r_out_ovf  <= w_cand_ovf;
                if (w_cand_ovf && (r_ovf_count != CNT_MAX)) begin
                    r_ovf_count <= r_ovf_count + 1'b1;
                end
            end
            if (w_drop) begin
                r_dropped <= 1'b1;
            end
        end
    end

`ifdef B01_COLLECTOR_PARITY_EN
    logic r_out_par;

    // Parity is registered alongside the word it describes.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_par <= 1'b0;
        end else if (w_load) begin
            r_out_par <= ^w_cand_word;
        end
    end

    assign out_par = r_out_par;
`endif

    assign out_word  = r_out_word;
    assign out_ovf   = r_out_ovf;
    assign out_valid = (r_state == ST_FULL);
    assign ovf_count = r_ovf_count;
    assign dropped   = r_dropped;

endmodule

// File: tb/tb_b01_collector.sv
// Testbench for b01_collector.
// A queue-based reference model tracks the words and handshakes.
// It is compared every cycle, and directed spec scenarios are followed by a randomized run.
module tb_b01_collector;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             outp;
    logic             overflw;
    logic             sample;
    logic [WIDTH-1:0] out_word;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] ovf_count;
    logic             dropped;
`ifdef B01_COLLECTOR_PARITY_EN
    logic             out_par;
`endif

    int n_cmp = 0;
    int n_err = 0;

    b01_collector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .outp      (outp),
        .overflw   (overflw),
        .sample    (sample),
        .out_word  (out_word),
        .out_ovf   (out_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf_count (ovf_count),
        .dropped   (dropped)
`ifdef B01_COLLECTOR_PARITY_EN
        ,
        .out_par   (out_par)
`endif
    );

    always #5 clock = ~clock;

    // Reference model state
    int               m_bits[$];
    bit               m_acc;
    bit               m_valid;
    bit [WIDTH-1:0]   m_word;
    bit               m_ovf;
    int               m_cnt;
    bit               m_dropped;
    int               m_words_loaded;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // The reference model collects bits in a queue.
    // When WIDTH bits are queued, it builds the word and applies the
    // single-entry register rules.
    task automatic model_update();
        bit             fire;
        bit             complete;
        bit [WIDTH-1:0] cw;
        bit             cf;
        if (reset) begin
            m_bits.delete();
            m_acc = 0; m_valid = 0; m_word = '0; m_ovf = 0;
            m_cnt = 0; m_dropped = 0;
            return;
        end
        fire     = m_valid && out_ready;
        complete = 0;
        cw       = '0;
        cf       = 0;
        if (sample) begin
            m_bits.push_back(int'(outp));
            m_acc = m_acc | overflw;
            if (m_bits.size() == WIDTH) begin
                complete = 1;
                for (int i = 0; i < WIDTH; i++) cw[i] = m_bits[i][0];
                cf = m_acc;
`ifdef B01_COLLECTOR_PARITY_EN
                if ((^cw) == 1'b1) cf = 1;
`endif
                m_bits.delete();
                m_acc = 0;
            end
        end
        if (complete) begin
            if (!m_valid || fire) begin
                m_valid = 1; m_word = cw; m_ovf = cf;
                m_words_loaded++;
                if (cf && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end else begin
                m_dropped = 1;
            end
        end else if (fire) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("out_valid", out_valid, m_valid);
        check("out_word", out_word, m_word);
        check("out_ovf", out_ovf, m_ovf);
        check("ovf_count", ovf_count, m_cnt);
        check("dropped", dropped, m_dropped);
`ifdef B01_COLLECTOR_PARITY_EN
        check("out_par", out_par, ^m_word);
`endif
    endtask

    task automatic step(input logic r, input logic s, input logic o, input logic v, input logic rd);
        reset = r; sample = s; outp = o; overflw = v; out_ready = rd;
        @(posedge clock);
        model_update();
        #1;
        compare_all();
    endtask

    // Send one word with continuous sample=1. ovf_mask marks the samples
    // that carry overflw. ready_mask gives out_ready for each of those cycles.
    task automatic send_word(input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] ovf_mask,
                             input logic [WIDTH-1:0] ready_mask);
        for (int i = 0; i < WIDTH; i++) step(1'b0, 1'b1, w[i], ovf_mask[i], ready_mask[i]);
    endtask

    initial begin
        logic [WIDTH-1:0] w_a;
        w_a = 8'h4D;
        m_words_loaded = 0;
        reset = 1; sample = 0; outp = 0; overflw = 0; out_ready = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_valid", out_valid, 0);
        check("rst_word", out_word, 0);
        check("rst_cnt", ovf_count, 0);
        check("rst_drop", dropped, 0);

        // The first test word has bits 1,0,1,1,0,0,1,0 LSB-first, giving 8'h4D.
        send_word(w_a, 8'h00, 8'h00);
        check("t1_valid", out_valid, 1);
        check("t1_word", out_word, 8'h4D);
`ifndef B01_COLLECTOR_PARITY_EN
        check("t1_ovf", out_ovf, 0);
        check("t1_cnt", ovf_count, 0);
`endif

        // Test overflw on the 3rd sample with ready=1, then repeat the word without overflw.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(w_a, 8'h04, 8'hFF);
        check("t2_ovf", out_ovf, 1);
        check("t2_cnt", ovf_count, 1);
        send_word(w_a, 8'h00, 8'hFF);
`ifndef B01_COLLECTOR_PARITY_EN
        check("t2b_ovf", out_ovf, 0);
        check("t2b_cnt", ovf_count, 1);
`endif

        // Send two words with out_ready=0: the first is kept and the second is dropped.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h5A, 8'h00, 8'h00);
        check("t3_nodrop", dropped, 0);
        send_word(8'hA5, 8'hFF, 8'h00);
        check("t3_word", out_word, 8'h5A);
        check("t3_drop", dropped, 1);
        check("t3_cnt", ovf_count, 0);

        // Assert ready only on completion cycles: words pass back-to-back with no drop.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) send_word(8'(k * 37 + 3), 8'h00, 8'h80);
        check("t4_drop", dropped, 0);
        check("t4_word", out_word, 8'(3 * 37 + 3));

        // Toggle sample over 16 cycles: exactly one word is produced.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        m_words_loaded = 0;
        for (int i = 0; i < 16; i++) step(1'b0, (i % 2 == 0), w_a[i / 2], 1'b0, 1'b0);
        check("t5_words", m_words_loaded, 1);
        check("t5_word", out_word, 8'h4D);
        check("t5_valid", out_valid, 1);

        // Reset after 5 samples: the partial word is lost, and 8 more samples are needed.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_not_yet", out_valid, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t6_valid", out_valid, 1);
        check("t6_word", out_word, 8'h80);

`ifdef B01_COLLECTOR_PARITY_EN
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h07, 8'h00, 8'hFF);
        check("p_par7", out_par, 1);
        check("p_ovf7", out_ovf, 1);
        send_word(8'h03, 8'h00, 8'hFF);
        check("p_par3", out_par, 0);
        check("p_ovf3", out_ovf, 0);
`endif

        // Random run: a heavy-overflow phase drives the count to saturation,
        // then a mixed phase follows.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 1500; i++)
            step(1'b0, 1'b1, 1'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
        check("sat_cnt", ovf_count, 15);
        for (int i = 0; i < 4000; i++)
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7), 1'($urandom),
                 ($urandom_range(0, 19) == 0), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
